alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter RF_INIT, default 8'h00, giving the reset value of every register-file entry.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: an instruction is offered.
REQ-005 SHALL have port in_ready, output, 1: the block can accept an instruction.
REQ-006 SHALL have port in_instr, input, 9: fields op[8:6], ra[5:3], rb[2:0].
REQ-007 SHALL have port in_branch, input, 1: the offered instruction is biz.
REQ-008 SHALL have ports alu_cmd (output, 3), alu_a (output, 8), alu_b (output, 8), alu_branch (output, 1), alu_sc_i (output, 1), driving the combinational ALU.
REQ-009 SHALL have ports alu_rslt (input, 8) and alu_sc_o (input, 1), returned by the ALU.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when an instruction retires.
REQ-011 SHALL have port branch_taken, output, 1: one-cycle pulse coincident with done.
REQ-012 SHALL have ports zero_flag, pari_flag, sc_flag, each output, 1: the registered status flags.
REQ-013 SHALL have ports rd_addr (input, 3) and rd_data (output, 8): combinational debug read of the register file.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE and WB; in_ready SHALL be 1 only in IDLE.
REQ-015 SHALL, on in_valid & in_ready, latch in_instr/in_branch and move IDLE->ISSUE; in_valid outside IDLE is ignored.
REQ-016 SHALL, in ISSUE, drive alu_cmd=op, alu_a=RF[ra], alu_b=RF[rb], alu_branch=latched branch, then move ISSUE->WB.
REQ-017 SHALL, at the ISSUE->WB edge, register alu_rslt and alu_sc_o; in WB write the result to RF[ra], pulse done, and return to IDLE (accept-to-done = 2 cycles, throughput 1 per 3 cycles).
REQ-018 SHALL drive alu_cmd/alu_a/alu_b/alu_branch/alu_sc_i to 0 outside ISSUE.
REQ-019 SHALL set zero_flag = (result == 8'h00) and pari_flag = ^result, computed internally from the captured result, on every retire.
REQ-020 SHALL update sc_flag from captured alu_sc_o only for op 000 (add), 001 (sub) and 110 (shift); other ops leave it unchanged.
REQ-021 SHALL treat branch & op==011 as a branch: suppress the RF write, update flags, and pulse branch_taken iff result == 0.
REQ-022 SHALL treat branch with op!=011 as an ordinary instruction with branch_taken=0, but still drive alu_branch=1.
REQ-023 SHALL return the pre-write value on rd_data when rd_addr equals the WB write address in the same cycle.
REQ-024 SHALL apply 8-bit wrap-around to all values; the block performs no arithmetic of its own beyond the flag reductions.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force IDLE, all RF entries to RF_INIT, all flags, done and branch_taken to 0, and all alu_* outputs to 0.
REQ-026 SHALL abandon an in-flight instruction on reset mid-operation: no RF write, no done pulse.
REQ-027 SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL, with ALU_ISSUE_SC_CHAIN_EN defined, drive alu_sc_i = sc_flag during ISSUE.
REQ-029 SHALL, without ALU_ISSUE_SC_CHAIN_EN, tie alu_sc_i to 0 and hold sc_flag at 0 permanently.

Structure
REQ-030 SHALL take the opcode enum (ADD, SUB, AND, XOR, SLT, MOV, SHL, REV), the FSM state enum and the instruction field widths from shared package alu_pkg.
REQ-031 SHALL place the 8x8 register file, with 1 combinational-read internal port, the debug read port and 1 write port, in sub-module rf8x8.

Verification
REQ-032 SHALL cover: RF_INIT=0, RF[1]=8'h05, RF[2]=8'h03, ADD ra=1 rb=2, ALU model present -> done 2 cycles after accept, RF[1]=8'h08, zero_flag=0, pari_flag=1.
REQ-033 SHALL cover, with SC_CHAIN_EN: ADD 8'hFF+8'h01 -> sc_flag=1; next ADD 8'h00+8'h00 -> alu_sc_i=1 in ISSUE, result 8'h01.
REQ-034 SHALL cover: branch XOR with RF[ra]=0 -> branch_taken=1 and RF unchanged; with RF[ra]=8'h10 -> branch_taken=0.
REQ-035 SHALL cover: in_valid held high for 6 cycles -> exactly 2 accepts, in_ready low in ISSUE and WB.
REQ-036 SHALL cover: rst_n pulsed low during ISSUE -> no done, target register keeps its prior value, in_ready=1 after release.
REQ-037 SHALL cover, without SC_CHAIN_EN: SUB 8'h00-8'h01 -> alu_sc_i=0 and sc_flag stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue slice: opcode and FSM enums, field widths,
// and the helper that says which opcodes produce a carry/borrow/shift-out.
package alu_pkg;

  localparam int OP_W     = 3;
  localparam int REG_W    = 3;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int INSTR_W  = OP_W + 2 * REG_W;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_SLT = 3'b100,
    OP_MOV = 3'b101,
    OP_SHL = 3'b110,
    OP_REV = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  function automatic logic updatesSc(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/rf8x8.sv
// 8x8 register file: one combinational internal read port, one combinational
// debug read port, one synchronous write port; every entry resets to RF_INIT.
module rf8x8
  import alu_pkg::*;
#(
  parameter logic [DATA_W-1:0] RF_INIT = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  input  logic [REG_W-1:0]  i_dbgAddr,
  output logic [DATA_W-1:0] o_dbgData
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= RF_INIT;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads see the stored value, so a same-cycle write is not yet visible.
  assign o_rdata   = r_mem[i_raddr];
  assign o_dbgData = r_mem[i_dbgAddr];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback sequencer for an external combinational ALU (IDLE->ISSUE->WB).
// Optional macro ALU_ISSUE_SC_CHAIN_EN feeds sc_flag back into alu_sc_i.
module alu_issue
  import alu_pkg::*;
#(
  parameter logic [DATA_W-1:0] RF_INIT = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_branch,
  output logic [OP_W-1:0]    alu_cmd,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic               alu_branch,
  output logic               alu_sc_i,
  input  logic [DATA_W-1:0]  alu_rslt,
  input  logic               alu_sc_o,
  output logic               done,
  output logic               branch_taken,
  output logic               zero_flag,
  output logic               pari_flag,
  output logic               sc_flag,
  input  logic [REG_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]  rd_data
);

  state_e            r_state;
  state_e            w_nextState;
  opcode_e           r_op;
  logic [REG_W-1:0]  r_ra;
  logic              r_branch;
  logic [DATA_W-1:0] r_opB;
  logic [DATA_W-1:0] r_rslt;
  logic              r_zeroFlag;
  logic              r_pariFlag;
  logic              r_scFlag;

  logic              w_accept;
  logic              w_isBranch;
  logic              w_we;
  logic [REG_W-1:0]  w_rfRaddr;
  logic [DATA_W-1:0] w_rfRdata;

  assign w_accept   = in_valid && (r_state == ST_IDLE);
  assign w_isBranch = r_branch && (r_op == OP_XOR);
  assign w_we       = (r_state == ST_WB) && !w_isBranch;

  // Single read port: rb is fetched while accepting, ra during ISSUE.
  assign w_rfRaddr = (r_state == ST_ISSUE) ? r_ra : in_instr[REG_W-1:0];

  rf8x8 #(
    .RF_INIT(RF_INIT)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we),
    .i_waddr  (r_ra),
    .i_wdata  (r_rslt),
    .i_raddr  (w_rfRaddr),
    .o_rdata  (w_rfRdata),
    .i_dbgAddr(rd_addr),
    .o_dbgData(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_nextState = ST_ISSUE;
      ST_ISSUE: w_nextState = ST_WB;
      ST_WB:    w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    done         = 1'b0;
    branch_taken = 1'b0;
    alu_cmd      = '0;
    alu_a        = '0;
    alu_b        = '0;
    alu_branch   = 1'b0;
    alu_sc_i     = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_ISSUE: begin
        alu_cmd    = r_op;
        alu_a      = w_rfRdata;
        alu_b      = r_opB;
        alu_branch = r_branch;
`ifdef ALU_ISSUE_SC_CHAIN_EN
        alu_sc_i   = r_scFlag;
`endif
      end
      ST_WB: begin
        done         = 1'b1;
        branch_taken = w_isBranch && (r_rslt == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_ADD;
      r_ra     <= '0;
      r_branch <= 1'b0;
      r_opB    <= '0;
      r_rslt   <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= opcode_e'(in_instr[INSTR_W-1 -: OP_W]);
        r_ra     <= in_instr[2*REG_W-1 -: REG_W];
        r_branch <= in_branch;
        r_opB    <= w_rfRdata;
      end
      if (r_state == ST_ISSUE) begin
        r_rslt <= alu_rslt;
      end
    end
  end

  // Flags change only on the edge that retires the instruction out of WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zeroFlag <= 1'b0;
      r_pariFlag <= 1'b0;
    end else if (r_state == ST_WB) begin
      r_zeroFlag <= (r_rslt == '0);
      r_pariFlag <= ^r_rslt;
    end
  end

`ifdef ALU_ISSUE_SC_CHAIN_EN
  logic r_scOut;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scOut  <= 1'b0;
      r_scFlag <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE) begin
        r_scOut <= alu_sc_o;
      end
      if ((r_state == ST_WB) && updatesSc(r_op)) begin
        r_scFlag <= r_scOut;
      end
    end
  end
`else
  logic w_unusedScOut;

  assign w_unusedScOut = alu_sc_o;
  assign r_scFlag      = 1'b0;
`endif

  assign zero_flag = r_zeroFlag;
  assign pari_flag = r_pariFlag;
  assign sc_flag   = r_scFlag;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: models the external ALU, drives a vector
// table plus throughput, reset-abort and carry-chain sequences.
module tb_alu_issue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_instr;
  logic       in_branch;
  logic [2:0] alu_cmd;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_branch;
  logic       alu_sc_i;
  logic [7:0] alu_rslt;
  logic       alu_sc_o;
  logic       done;
  logic       branch_taken;
  logic       zero_flag;
  logic       pari_flag;
  logic       sc_flag;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;

  logic       loadEn;
  logic [7:0] loadVal;

  always #5 clk = ~clk;

  alu_issue #(.RF_INIT(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_branch   (in_branch),
    .alu_cmd     (alu_cmd),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_branch  (alu_branch),
    .alu_sc_i    (alu_sc_i),
    .alu_rslt    (alu_rslt),
    .alu_sc_o    (alu_sc_o),
    .done        (done),
    .branch_taken(branch_taken),
    .zero_flag   (zero_flag),
    .pari_flag   (pari_flag),
    .sc_flag     (sc_flag),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  // Reference ALU: {sc_o, result}. A load override lets the bench seed registers.
  function automatic logic [8:0] aluModel(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic sci);
    logic [8:0] t;
    t = '0;
    case (op)
      3'b000: t = {1'b0, a} + {1'b0, b} + {8'd0, sci};
      3'b001: t = {1'b0, a} - {1'b0, b} - {8'd0, sci};
      3'b010: t = {1'b0, a & b};
      3'b011: t = {1'b0, a ^ b};
      3'b100: t = {8'd0, (a < b)};
      3'b101: t = {1'b0, b};
      3'b110: t = {a[7], a[6:0], 1'b0};
      default: for (int i = 0; i < 8; i++) t[i] = a[7-i];
    endcase
    return t;
  endfunction

  always_comb begin
    {alu_sc_o, alu_rslt} = aluModel(alu_cmd, alu_a, alu_b, alu_sc_i);
    if (loadEn) alu_rslt = loadVal;
  end

  typedef struct {
    logic [2:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       br;
    logic       ld;
    logic [7:0] ldVal;
    logic [7:0] expRslt;
    logic       expTaken;
    logic       expSc;
    string      name;
  } vec_t;

  typedef struct {
    logic [2:0] ra;
    logic [7:0] oldVal;
    logic [7:0] newVal;
    logic [7:0] rslt;
    logic       taken;
  } sb_t;

  sb_t        sbQ[$];
  logic [7:0] rfModel[8];
  logic       scModel;
  int         errors = 0;
  int         checks = 0;
  vec_t       tbl[15];

  function automatic vec_t mk(input string name, input logic [2:0] op, input logic [2:0] ra,
                              input logic [2:0] rb, input logic br, input logic ld,
                              input logic [7:0] ldVal, input logic [7:0] expRslt,
                              input logic expTaken, input logic expSc);
    vec_t v;
    v.name = name; v.op = op; v.ra = ra; v.rb = rb; v.br = br; v.ld = ld;
    v.ldVal = ldVal; v.expRslt = expRslt; v.expTaken = expTaken; v.expSc = expSc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 8; i++) rfModel[i] = 8'h00;
    scModel = 1'b0;
    sbQ.delete();
  endtask

  // Issues one instruction and follows it through ISSUE, WB and back to IDLE.
  task automatic applyStimulus(input vec_t v);
    int         n;
    logic [7:0] a;
    logic [7:0] b;
    logic       sci;
    logic       wr;
    sb_t        e;
    sb_t        got;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput({v.name, " in_ready idle"}, 32'(in_ready), 32'd1);
    a = rfModel[v.ra];
    b = rfModel[v.rb];
`ifdef ALU_ISSUE_SC_CHAIN_EN
    sci = scModel;
`else
    sci = 1'b0;
`endif
    in_valid  = 1'b1;
    in_instr  = {v.op, v.ra, v.rb};
    in_branch = v.br;
    loadEn    = v.ld;
    loadVal   = v.ldVal;
    wr        = !(v.br && (v.op == 3'b011));
    e.ra      = v.ra;
    e.oldVal  = a;
    e.newVal  = wr ? v.expRslt : a;
    e.rslt    = v.expRslt;
    e.taken   = v.expTaken;
    sbQ.push_back(e);

    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_branch = 1'b0;
    checkOutput({v.name, " done in ISSUE"},   32'(done),       32'd0);
    checkOutput({v.name, " ready in ISSUE"},  32'(in_ready),   32'd0);
    checkOutput({v.name, " alu_cmd"},         32'(alu_cmd),    32'(v.op));
    checkOutput({v.name, " alu_a"},           32'(alu_a),      32'(a));
    checkOutput({v.name, " alu_b"},           32'(alu_b),      32'(b));
    checkOutput({v.name, " alu_branch"},      32'(alu_branch), 32'(v.br));
    checkOutput({v.name, " alu_sc_i"},        32'(alu_sc_i),   32'(sci));

    @(posedge clk); #1;
    loadEn = 1'b0;
    checkOutput({v.name, " done in WB"},  32'(done),     32'd1);
    checkOutput({v.name, " ready in WB"}, 32'(in_ready), 32'd0);
    if (sbQ.size() == 0) begin
      checkOutput({v.name, " scoreboard empty"}, 32'd0, 32'd1);
      got = e;
    end else begin
      got = sbQ.pop_front();
    end
    checkOutput({v.name, " branch_taken"}, 32'(branch_taken), 32'(got.taken));
    rd_addr = got.ra;
    #1;
    checkOutput({v.name, " rd_data pre-write"}, 32'(rd_data), 32'(got.oldVal));

    @(posedge clk); #1;
    checkOutput({v.name, " done after WB"},   32'(done),         32'd0);
    checkOutput({v.name, " taken after WB"},  32'(branch_taken), 32'd0);
    checkOutput({v.name, " rd_data written"}, 32'(rd_data),      32'(got.newVal));
    checkOutput({v.name, " zero_flag"},       32'(zero_flag),    32'(got.rslt == 8'h00));
    checkOutput({v.name, " pari_flag"},       32'(pari_flag),    32'(^got.rslt));
`ifdef ALU_ISSUE_SC_CHAIN_EN
    if (v.op == 3'b000 || v.op == 3'b001 || v.op == 3'b110) scModel = v.expSc;
`endif
    checkOutput({v.name, " sc_flag"}, 32'(sc_flag), 32'(scModel));
    rfModel[got.ra] = got.newVal;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepts;
    int notReady;
    int dones;

    tbl[0]  = mk("load r1",     OP_MOV, 3'd1, 3'd0, 1'b0, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0);
    tbl[1]  = mk("load r2",     OP_MOV, 3'd2, 3'd0, 1'b0, 1'b1, 8'h03, 8'h03, 1'b0, 1'b0);
    tbl[2]  = mk("add r1 r2",   OP_ADD, 3'd1, 3'd2, 1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 1'b0);
    tbl[3]  = mk("br add r2",   OP_ADD, 3'd2, 3'd2, 1'b1, 1'b0, 8'h00, 8'h06, 1'b0, 1'b0);
    tbl[4]  = mk("load r3",     OP_MOV, 3'd3, 3'd0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    tbl[5]  = mk("load r4",     OP_MOV, 3'd4, 3'd0, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
    tbl[6]  = mk("shl r3",      OP_SHL, 3'd3, 3'd0, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b1);
    tbl[7]  = mk("and r3 r4",   OP_AND, 3'd3, 3'd4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[8]  = mk("slt r7 r4",   OP_SLT, 3'd7, 3'd4, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
    tbl[9]  = mk("rev r4",      OP_REV, 3'd4, 3'd0, 1'b0, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0);
    tbl[10] = mk("xor r1 r1",   OP_XOR, 3'd1, 3'd1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[11] = mk("biz r1 zero", OP_XOR, 3'd1, 3'd5, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tbl[12] = mk("load r6",     OP_MOV, 3'd6, 3'd0, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 1'b0);
    tbl[13] = mk("biz r6 nz",   OP_XOR, 3'd6, 3'd5, 1'b1, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0);
    tbl[14] = mk("biz r6 r6",   OP_XOR, 3'd6, 3'd6, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_branch = 1'b0;
    loadEn    = 1'b0;
    loadVal   = '0;
    rd_addr   = 3'd3;
    resetModel();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset in_ready",     32'(in_ready),     32'd1);
    checkOutput("reset done",         32'(done),         32'd0);
    checkOutput("reset branch_taken", 32'(branch_taken), 32'd0);
    checkOutput("reset zero_flag",    32'(zero_flag),    32'd0);
    checkOutput("reset pari_flag",    32'(pari_flag),    32'd0);
    checkOutput("reset sc_flag",      32'(sc_flag),      32'd0);
    checkOutput("reset alu_cmd",      32'(alu_cmd),      32'd0);
    checkOutput("reset alu_a",        32'(alu_a),        32'd0);
    checkOutput("reset rd_data",      32'(rd_data),      32'd0);

    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Hold in_valid for six cycles: two accepts, four cycles not ready.
    accepts  = 0;
    notReady = 0;
    dones    = 0;
    in_valid = 1'b1;
    in_instr = {OP_AND, 3'd2, 3'd2};
    for (int c = 0; c < 6; c++) begin
      if (in_ready) accepts++;
      else notReady++;
      @(posedge clk); #1;
      if (done) dones++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rd_addr  = 3'd2;
    #1;
    checkOutput("burst accepts",   32'(accepts),   32'd2);
    checkOutput("burst not ready", 32'(notReady),  32'd4);
    checkOutput("burst dones",     32'(dones),     32'd2);
    checkOutput("burst r2",        32'(rd_data),   32'h06);
    checkOutput("burst zero_flag", 32'(zero_flag), 32'd0);
    checkOutput("burst pari_flag", 32'(pari_flag), 32'd0);

    // Reset during ISSUE abandons the load into r7.
    in_valid = 1'b1;
    in_instr = {OP_MOV, 3'd7, 3'd0};
    loadEn   = 1'b1;
    loadVal  = 8'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("abort in ISSUE", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort done in reset", 32'(done),    32'd0);
    checkOutput("abort alu_cmd",       32'(alu_cmd), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    loadEn = 1'b0;
    resetModel();
    rd_addr = 3'd7;
    #1;
    checkOutput("abort in_ready after release", 32'(in_ready), 32'd1);
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checkOutput("abort no done", 32'(dones),   32'd0);
    checkOutput("abort r7 kept", 32'(rd_data), 32'h00);
    @(negedge clk);

`ifdef ALU_ISSUE_SC_CHAIN_EN
    applyStimulus(mk("chain load r3", OP_MOV, 3'd3, 3'd0, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0));
    applyStimulus(mk("chain load r4", OP_MOV, 3'd4, 3'd0, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0));
    applyStimulus(mk("chain add ff+1", OP_ADD, 3'd3, 3'd4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1));
    applyStimulus(mk("chain add 0+0", OP_ADD, 3'd5, 3'd5, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0));
`else
    applyStimulus(mk("nochain load r4", OP_MOV, 3'd4, 3'd0, 1'b0, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0));
    applyStimulus(mk("nochain sub 0-1", OP_SUB, 3'd5, 3'd4, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1));
    applyStimulus(mk("nochain add 0+0", OP_ADD, 3'd6, 3'd6, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
